// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: PC base, NOP encoding and fetch FSM states.
// The state encoding is also decoded by the debug/status block.
package fetch_stage_pkg;

  localparam logic [31:0] PcBase   = 32'h0000_3000;
  localparam logic [31:0] NopInstr = 32'h0000_0000;

  typedef enum logic [0:0] {
    FsRun  = 1'b0,
    FsHalt = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] abs_pc(logic [31:0] off, logic [31:0] base);
    return off + base;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: next-PC/hazard controls in, PC feedback, IF/ID register and fault status out.
interface fetch_stage_if;
  logic [31:0] next_pc_off;
  logic        stall;
  logic        flush;
  logic [31:0] pc_off;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc8;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  modport master (
    output next_pc_off, stall, flush,
    input  pc_off, if_id_instr, if_id_pc, if_id_pc8, if_id_valid, fetch_fault, fault_pc
  );

  modport slave (
    input  next_pc_off, stall, flush,
    output pc_off, if_id_instr, if_id_pc, if_id_pc8, if_id_valid, fetch_fault, fault_pc
  );
endinterface

// File: rtl/fetch_stage_im_rom.sv
// Instruction ROM: IM_DEPTH x 32 words, asynchronous read.
// The image is supplied at elaboration time as a flat vector, word 0 in the low 32 bits.
module fetch_stage_im_rom #(
  parameter int unsigned           IM_DEPTH = 4096,
  parameter logic [IM_DEPTH*32-1:0] IM_INIT = '0
) (
  input  logic [$clog2(IM_DEPTH)-1:0] addr,
  output logic [31:0]                 rdata
);

  assign rdata = IM_INIT[{addr, 5'b0_0000} +: 32];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, RUN/HALT fault FSM and IF/ID pipeline register.
// A bad PC (misaligned or beyond the ROM) halts fetch until reset.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0]            PC_BASE  = PcBase,
  parameter int unsigned            IM_DEPTH = 4096,
  parameter logic [IM_DEPTH*32-1:0] IM_INIT  = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  bus
);

  localparam int unsigned AddrW   = $clog2(IM_DEPTH);
  localparam logic [31:0] ImBytes = 32'(IM_DEPTH * 4);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  fault_pc_q, fault_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ipc_q, ipc_d;
  logic [31:0]  ipc8_q, ipc8_d;
  logic         valid_q, valid_d;

  logic [31:0]  rom_data;
  logic         bad_pc;
  logic         ifid_clear;
  logic         ifid_load;

  fetch_stage_im_rom #(
    .IM_DEPTH (IM_DEPTH),
    .IM_INIT  (IM_INIT)
  ) u_im_rom (
    .addr  (pc_q[AddrW+1:2]),
    .rdata (rom_data)
  );

  assign bad_pc = (pc_q[1:0] != 2'b00) || (pc_q >= ImBytes);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    ipc8_d     = ipc8_q;
    valid_d    = valid_q;
    ifid_clear = 1'b0;
    ifid_load  = 1'b0;

    // Stalled cycles never evaluate bad_pc; the check waits until the hazard clears.
    unique case (state_q)
      FsRun: begin
        if (!bus.stall) begin
          if (bad_pc) begin
            state_d    = FsHalt;
            fault_d    = 1'b1;
            fault_pc_d = abs_pc(pc_q, PC_BASE);
            ifid_clear = 1'b1;
          end else begin
            pc_d      = bus.next_pc_off;
            ifid_load = 1'b1;
          end
        end
      end
      FsHalt: begin
        if (!bus.stall) ifid_clear = 1'b1;
      end
      default: state_d = FsRun;
    endcase

    if (bus.flush || ifid_clear) begin
      instr_d = NopInstr;
      valid_d = 1'b0;
      ipc_d   = PC_BASE;
      ipc8_d  = PC_BASE + 32'd8;
    end else if (ifid_load) begin
      instr_d = rom_data;
      valid_d = 1'b1;
      ipc_d   = abs_pc(pc_q, PC_BASE);
      ipc8_d  = abs_pc(pc_q, PC_BASE) + 32'd8;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FsRun;
      pc_q       <= 32'd0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
      instr_q    <= NopInstr;
      ipc_q      <= PC_BASE;
      ipc8_q     <= PC_BASE + 32'd8;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
      ipc8_q     <= ipc8_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.pc_off      = pc_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc    = ipc_q;
  assign bus.if_id_pc8   = ipc8_q;
  assign bus.if_id_valid = valid_q;
  assign bus.fetch_fault = fault_q;
  assign bus.fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int unsigned Depth = 16;
  localparam logic [31:0] Base  = 32'h0000_3000;

  function automatic logic [31:0] img_word(int unsigned i);
    return (32'h9e37_79b9 * (i + 1)) ^ 32'h1357_0000;
  endfunction

  function automatic logic [Depth*32-1:0] make_image();
    logic [Depth*32-1:0] r;
    r = '0;
    for (int i = 0; i < Depth; i++) r[i*32 +: 32] = img_word(i);
    return r;
  endfunction

  localparam logic [Depth*32-1:0] Image = make_image();

  logic clk;
  logic reset;
  fetch_stage_if bus();

  fetch_stage #(
    .PC_BASE  (Base),
    .IM_DEPTH (Depth),
    .IM_INIT  (Image)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic [31:0] m_pc       = 32'd0;
  logic        m_halted   = 1'b0;
  logic        m_fault    = 1'b0;
  logic [31:0] m_fault_pc = 32'd0;
  logic [31:0] m_instr    = 32'd0;
  logic [31:0] m_ipc      = Base;
  logic [31:0] m_ipc8     = Base + 32'd8;
  logic        m_valid    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [31:0] npc, input logic st,
                            input logic fl);
    logic [31:0] cur;
    logic        bad, kill, load;
    if (r) begin
      m_pc = 0; m_halted = 0; m_fault = 0; m_fault_pc = 0;
      m_instr = 0; m_ipc = Base; m_ipc8 = Base + 32'd8; m_valid = 0;
      return;
    end
    cur  = m_pc;
    bad  = (cur % 4 != 0) || (cur >= 32'(Depth * 4));
    kill = 1'b0;
    load = 1'b0;
    if (m_halted) begin
      kill = !st;
    end else if (!st) begin
      if (bad) begin
        m_halted = 1; m_fault = 1; m_fault_pc = cur + Base; kill = 1;
      end else begin
        m_pc = npc; load = 1;
      end
    end
    if (fl) begin
      m_instr = 0; m_valid = 0; m_ipc = Base; m_ipc8 = Base + 32'd8;
    end else if (kill) begin
      m_instr = 0; m_valid = 0;
    end else if (load) begin
      m_instr = img_word(cur / 4); m_valid = 1;
      m_ipc = cur + Base; m_ipc8 = cur + Base + 32'd8;
    end
  endtask

  task automatic step(input logic r, input logic [31:0] npc, input logic st, input logic fl);
    reset           = r;
    bus.next_pc_off = npc;
    bus.stall       = st;
    bus.flush       = fl;
    model_edge(r, npc, st, fl);
    @(posedge clk);
    #1;
    check_eq("pc_off", bus.pc_off, m_pc);
    check_eq("valid", 32'(bus.if_id_valid), 32'(m_valid));
    check_eq("instr", bus.if_id_instr, m_instr);
    check_eq("fault", 32'(bus.fetch_fault), 32'(m_fault));
    check_eq("fault_pc", bus.fault_pc, m_fault_pc);
    if (m_valid) begin
      check_eq("if_id_pc", bus.if_id_pc, m_ipc);
      check_eq("if_id_pc8", bus.if_id_pc8, m_ipc8);
    end
  endtask

  initial begin
    logic        r, st, fl;
    logic [31:0] npc;
    int unsigned sel;

    reset = 1'b1; bus.next_pc_off = 32'h40; bus.stall = 1'b0; bus.flush = 1'b0;

    // T1: reset held 3 cycles
    for (int i = 0; i < 3; i++) step(1'b1, 32'h40, 1'b0, 1'b0);
    check_eq("t1_rst_pc_off", bus.pc_off, 32'h0);
    check_eq("t1_rst_if_id_pc", bus.if_id_pc, 32'h3000);
    check_eq("t1_rst_pc8", bus.if_id_pc8, 32'h3008);
    step(1'b0, 32'h4, 1'b0, 1'b0);
    check_eq("t1_instr0", bus.if_id_instr, img_word(0));
    check_eq("t1_pc", bus.if_id_pc, 32'h3000);
    check_eq("t1_pc8", bus.if_id_pc8, 32'h3008);

    // T2: sequential fetch
    for (int i = 0; i < 5; i++) step(1'b0, m_pc + 32'd4, 1'b0, 1'b0);
    check_eq("t2_last_pc", bus.if_id_pc, 32'h3014);

    // T3: stall then flush under stall
    step(1'b0, 32'h8, 1'b0, 1'b0);
    step(1'b0, 32'h100, 1'b1, 1'b0);
    step(1'b0, 32'h100, 1'b1, 1'b0);
    check_eq("t3_stall_pc_off", bus.pc_off, 32'h8);
    step(1'b0, 32'h100, 1'b1, 1'b1);
    check_eq("t3_flush_valid", 32'(bus.if_id_valid), 32'h0);
    check_eq("t3_flush_instr", bus.if_id_instr, 32'h0);
    check_eq("t3_flush_pc_off", bus.pc_off, 32'h8);
    step(1'b0, 32'hc, 1'b0, 1'b0);

    // T4: misaligned PC
    step(1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h6, 1'b0, 1'b0);
    check_eq("t4_pc_off", bus.pc_off, 32'h6);
    step(1'b0, 32'h8, 1'b0, 1'b0);
    check_eq("t4_fault", 32'(bus.fetch_fault), 32'h1);
    check_eq("t4_fault_pc", bus.fault_pc, 32'h3006);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'($urandom_range(0, 1)), 1'b0);
    check_eq("t4_frozen_pc", bus.pc_off, 32'h6);

    // T5: out of range, with the bad cycle stalled
    step(1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h40, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_eq("t5_deferred", 32'(bus.fetch_fault), 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("t5_fault", 32'(bus.fetch_fault), 32'h1);
    check_eq("t5_fault_pc", bus.fault_pc, 32'h3040);

    // T6: reset out of HALT
    step(1'b1, 32'h0, 1'b0, 1'b0);
    check_eq("t6_fault_clr", 32'(bus.fetch_fault), 32'h0);
    check_eq("t6_pc_off", bus.pc_off, 32'h0);
    step(1'b0, 32'h4, 1'b0, 1'b0);
    check_eq("t6_instr0", bus.if_id_instr, img_word(0));
    check_eq("t6_valid", 32'(bus.if_id_valid), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 59) == 0);
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 39);
      if (sel == 0) npc = 32'($urandom_range(0, Depth * 4 + 8));
      else if (sel < 8) npc = 32'($urandom_range(0, Depth - 1)) << 2;
      else npc = (m_pc + 32'd4) % 32'(Depth * 4);
      step(r, npc, st, fl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
